// File: rtl/point_spawn_ctrl_pkg.sv
// Shared types and helpers for the point placement controller: game modes,
// map tile codes, the spawn FSM state set and the 6-bit coordinate LFSR.
package point_spawn_ctrl_pkg;

  localparam int MAP_WIDTH  = 64;
  localparam int MAP_HEIGHT = 48;

  typedef enum logic [1:0] {
    MODE_MENU  = 2'd0,
    MODE_GAME  = 2'd1,
    MODE_OVER  = 2'd2,
    MODE_PAUSE = 2'd3
  } game_mode;

  typedef enum logic [1:0] {
    TILE_EMPTY  = 2'd0,
    TILE_POINT  = 2'd1,
    TILE_SNAKE1 = 2'd2,
    TILE_SNAKE2 = 2'd3
  } tile_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_QUERY  = 3'd1,
    S_CHECK  = 3'd2,
    S_COMMIT = 3'd3,
    S_SCAN_Q = 3'd4,
    S_SCAN_C = 3'd5
  } spawn_state_t;

  // One LFSR step; an all-zero register would lock up, so it restarts from 1.
  function automatic logic [5:0] lfsr6_next(input logic [5:0] v);
    logic [5:0] s;
    s = (v == 6'd0) ? 6'd1 : v;
    return {s[4:1], s[0] ^ s[5], s[5]};
  endfunction

  // Fold a raw 6-bit value into 1..lim; the 7-bit intermediate keeps lim=63 exact.
  function automatic logic [5:0] wrap_coord(input logic [5:0] v, input logic [6:0] lim);
    logic [6:0] t;
    t = ({1'b0, v} % lim) + 7'd1;
    return t[5:0];
  endfunction

endpackage

// File: rtl/point_spawn_ctrl_if.sv
// Signal bundle between the point spawn controller and the game/map logic.
interface point_spawn_ctrl_if;
  import point_spawn_ctrl_pkg::*;

  game_mode   mode;
  logic       seed_load;
  logic [5:0] seed_x_in;
  logic [5:0] seed_y_in;
  logic       eat_req1;
  logic       eat_req2;
  logic [5:0] query_x;
  logic [5:0] query_y;
  tile_t      query_tile;
  logic       point_we;
  logic [5:0] point_x;
  logic [5:0] point_y;
  logic       point_valid;
  logic       busy;
  logic       score1_inc;
  logic       score2_inc;
  logic       spawn_fail;

  modport master (
    output mode, seed_load, seed_x_in, seed_y_in, eat_req1, eat_req2, query_tile,
    input  query_x, query_y, point_we, point_x, point_y, point_valid, busy,
           score1_inc, score2_inc, spawn_fail
  );

  modport slave (
    input  mode, seed_load, seed_x_in, seed_y_in, eat_req1, eat_req2, query_tile,
    output query_x, query_y, point_we, point_x, point_y, point_valid, busy,
           score1_inc, score2_inc, spawn_fail
  );

endinterface

// File: rtl/point_spawn_ctrl_arbiter.sv
// Eat-event arbiter: credits each snake that reached the live point and asks
// for exactly one respawn even when both snakes hit it on the same cycle.
module spawn_arbiter (
  input  logic clk_75,
  input  logic rst,
  input  logic i_eat_req1,
  input  logic i_eat_req2,
  input  logic i_point_valid,
  input  logic i_idle,
  output logic o_score1_inc,
  output logic o_score2_inc,
  output logic o_spawn_start
);

  logic w_accept;
  logic r_score1;
  logic r_score2;

  // Eats only count while a point is on the map and no placement is running.
  assign w_accept      = i_idle & i_point_valid;
  assign o_spawn_start = w_accept & (i_eat_req1 | i_eat_req2);
  assign o_score1_inc  = r_score1;
  assign o_score2_inc  = r_score2;

  // Score credits are registered so they appear one cycle after the eat.
  always_ff @(posedge clk_75) begin
    if (rst) begin
      r_score1 <= 1'b0;
      r_score2 <= 1'b0;
    end else begin
      r_score1 <= w_accept & i_eat_req1;
      r_score2 <= w_accept & i_eat_req2;
    end
  end

endmodule

// File: rtl/point_spawn_ctrl.sv
// Point placement controller: picks candidates from the seed or LFSR, probes
// the map one tile at a time, falls back to a raster scan, then commits.
module point_spawn_ctrl
  import point_spawn_ctrl_pkg::*;
#(
  parameter int X_MAX     = 62,
  parameter int Y_MAX     = 46,
  parameter int MAX_TRIES = 16
) (
  input logic               clk_75,
  input logic               rst,
  point_spawn_ctrl_if.slave bus
);

  localparam logic [5:0] LP_X_MAX    = 6'(X_MAX);
  localparam logic [5:0] LP_Y_MAX    = 6'(Y_MAX);
  localparam logic [6:0] LP_X_MOD    = 7'(X_MAX);
  localparam logic [6:0] LP_Y_MOD    = 7'(Y_MAX);
  localparam logic [4:0] LP_LAST_TRY = 5'(MAX_TRIES - 1);

  spawn_state_t r_state, w_state_nxt;
  logic [5:0]   r_cand_x, r_cand_y, w_cand_x_nxt, w_cand_y_nxt;
  logic [5:0]   r_lfsr_x, r_lfsr_y, w_lfsr_x_nxt, w_lfsr_y_nxt;
  logic [4:0]   r_tries, w_tries_nxt;
  logic [5:0]   r_point_x, r_point_y, w_point_x_nxt, w_point_y_nxt;
  logic         r_point_valid, w_point_valid_nxt;
  logic         r_spawn_fail, w_spawn_fail_nxt;
  logic         w_point_we;
  logic [5:0]   w_step_x, w_step_y;
  logic         w_idle, w_empty, w_spawn_start;
  logic         w_score1, w_score2;

  assign w_idle   = (r_state == S_IDLE);
  assign w_empty  = (bus.query_tile == TILE_EMPTY);
  // The LFSR register holds the previous candidate, so each step derives from it.
  assign w_step_x = wrap_coord(lfsr6_next(r_lfsr_x), LP_X_MOD);
  assign w_step_y = wrap_coord(lfsr6_next(r_lfsr_y), LP_Y_MOD);

  spawn_arbiter u_arbiter (
    .clk_75        (clk_75),
    .rst           (rst),
    .i_eat_req1    (bus.eat_req1),
    .i_eat_req2    (bus.eat_req2),
    .i_point_valid (r_point_valid),
    .i_idle        (w_idle),
    .o_score1_inc  (w_score1),
    .o_score2_inc  (w_score2),
    .o_spawn_start (w_spawn_start)
  );

  // The probe address is the current candidate; it simply holds while idle.
  assign bus.query_x     = r_cand_x;
  assign bus.query_y     = r_cand_y;
  assign bus.point_we    = w_point_we;
  assign bus.point_x     = r_point_x;
  assign bus.point_y     = r_point_y;
  assign bus.point_valid = r_point_valid;
  assign bus.busy        = ~w_idle;
  assign bus.score1_inc  = w_score1;
  assign bus.score2_inc  = w_score2;
  assign bus.spawn_fail  = r_spawn_fail;

  // FSM state and coordinate registers.
  always_ff @(posedge clk_75) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cand_x      <= 6'd0;
      r_cand_y      <= 6'd0;
      r_lfsr_x      <= 6'd1;
      r_lfsr_y      <= 6'd1;
      r_tries       <= 5'd0;
      r_point_x     <= 6'd0;
      r_point_y     <= 6'd0;
      r_point_valid <= 1'b0;
      r_spawn_fail  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cand_x      <= w_cand_x_nxt;
      r_cand_y      <= w_cand_y_nxt;
      r_lfsr_x      <= w_lfsr_x_nxt;
      r_lfsr_y      <= w_lfsr_y_nxt;
      r_tries       <= w_tries_nxt;
      r_point_x     <= w_point_x_nxt;
      r_point_y     <= w_point_y_nxt;
      r_point_valid <= w_point_valid_nxt;
      r_spawn_fail  <= w_spawn_fail_nxt;
    end
  end

  // Next-state and datapath decisions; leaving GAME mode overrides everything.
  always_comb begin
    w_state_nxt       = r_state;
    w_cand_x_nxt      = r_cand_x;
    w_cand_y_nxt      = r_cand_y;
    w_lfsr_x_nxt      = r_lfsr_x;
    w_lfsr_y_nxt      = r_lfsr_y;
    w_tries_nxt       = r_tries;
    w_point_x_nxt     = r_point_x;
    w_point_y_nxt     = r_point_y;
    w_point_valid_nxt = r_point_valid;
    w_spawn_fail_nxt  = 1'b0;
    w_point_we        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.seed_load) begin
          w_cand_x_nxt      = wrap_coord(bus.seed_x_in, LP_X_MOD);
          w_cand_y_nxt      = wrap_coord(bus.seed_y_in, LP_Y_MOD);
          w_lfsr_x_nxt      = w_cand_x_nxt;
          w_lfsr_y_nxt      = w_cand_y_nxt;
          w_tries_nxt       = 5'd0;
          w_point_valid_nxt = 1'b0;
          w_state_nxt       = S_QUERY;
        end else if (w_spawn_start) begin
          w_cand_x_nxt      = w_step_x;
          w_cand_y_nxt      = w_step_y;
          w_lfsr_x_nxt      = w_step_x;
          w_lfsr_y_nxt      = w_step_y;
          w_tries_nxt       = 5'd0;
          w_point_valid_nxt = 1'b0;
          w_state_nxt       = S_QUERY;
        end
      end
      S_QUERY: w_state_nxt = S_CHECK;
      S_CHECK: begin
        if (w_empty) begin
          w_point_x_nxt = r_cand_x;
          w_point_y_nxt = r_cand_y;
          w_state_nxt   = S_COMMIT;
        end else begin
          w_tries_nxt = r_tries + 5'd1;
          if (r_tries == LP_LAST_TRY) begin
            w_cand_x_nxt = 6'd1;
            w_cand_y_nxt = 6'd1;
            w_state_nxt  = S_SCAN_Q;
          end else begin
            w_cand_x_nxt = w_step_x;
            w_cand_y_nxt = w_step_y;
            w_lfsr_x_nxt = w_step_x;
            w_lfsr_y_nxt = w_step_y;
            w_state_nxt  = S_QUERY;
          end
        end
      end
      S_COMMIT: begin
        w_point_we        = 1'b1;
        w_point_valid_nxt = 1'b1;
        w_tries_nxt       = 5'd0;
        w_state_nxt       = S_IDLE;
      end
      S_SCAN_Q: w_state_nxt = S_SCAN_C;
      S_SCAN_C: begin
        if (w_empty) begin
          w_point_x_nxt = r_cand_x;
          w_point_y_nxt = r_cand_y;
          w_state_nxt   = S_COMMIT;
        end else if (r_cand_x != LP_X_MAX) begin
          w_cand_x_nxt = r_cand_x + 6'd1;
          w_state_nxt  = S_SCAN_Q;
        end else if (r_cand_y != LP_Y_MAX) begin
          w_cand_x_nxt = 6'd1;
          w_cand_y_nxt = r_cand_y + 6'd1;
          w_state_nxt  = S_SCAN_Q;
        end else begin
          w_spawn_fail_nxt = 1'b1;
          w_point_x_nxt    = 6'd0;
          w_point_y_nxt    = 6'd0;
          w_state_nxt      = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (!w_idle && (bus.mode != MODE_GAME)) begin
      w_state_nxt       = S_IDLE;
      w_cand_x_nxt      = r_cand_x;
      w_cand_y_nxt      = r_cand_y;
      w_point_x_nxt     = 6'd0;
      w_point_y_nxt     = 6'd0;
      w_point_valid_nxt = 1'b0;
      w_spawn_fail_nxt  = 1'b0;
      w_point_we        = 1'b0;
    end
  end

endmodule
